branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer in the Fetch stage. It supplies the predicted next PC from the current PC, combining its own hit with the direction bit from the 2-bit branch predictor. It carries the prediction down the pipeline to Execute, where it compares the prediction against the resolved branch and raises mispredict and redirect. It also installs and invalidates entries from resolved branches.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/btb_pred_pipe.sv | 42 ++++
 rtl/branch_target_buffer.sv | 109 ++++++++++
 tb/tb_branch_target_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch target buffer: next-PC source encodings
// and the prediction bundle carried from Fetch down to Execute.
package branch_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JAL    = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_bundle_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/btb_pred_pipe.sv
// F->D->E prediction registers. FlushD beats StallD on the D register;
// the E register holds during StallD and is cleared by FlushE.
module btb_pred_pipe
  import branch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_d,
  input  logic         flush_d,
  input  logic         flush_e,
  input  pred_bundle_t pred_f,
  output pred_bundle_t pred_e
);

  pred_bundle_t pred_p1;
  pred_bundle_t pred_p2;

  // Fetch -> Decode boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_p1 <= '0;
    end else if (flush_d) begin
      pred_p1 <= '0;
    end else if (!stall_d) begin
      pred_p1 <= pred_f;
    end
  end

  // Decode -> Execute boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_p2 <= '0;
    end else if (flush_e) begin
      pred_p2 <= '0;
    end else if (!stall_d) begin
      pred_p2 <= pred_p1;
    end
  end

  assign pred_e = pred_p2;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational Fetch lookup, prediction
// carried to Execute, resolution/redirect there, and table install/invalidate.
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        pred_taken,
  output logic        HitF,
  output logic        PredTakenF,
  output logic [31:0] PCNextPredF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic [31:0] PCE,
  input  logic [1:0]  PCsrcE,
  input  logic        BranchCondE,
  input  logic [31:0] PCTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [31:0]      target_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;

  pred_bundle_t pred_f;
  pred_bundle_t pred_e;

  logic install_e;
  logic invalidate_e;

  assign idx_f    = PCF[IDX_W+1:2];
  assign tag_f    = PCF[31:IDX_W+2];
  assign idx_e    = PCE[IDX_W+1:2];
  assign tag_e    = PCE[31:IDX_W+2];
  assign target_f = target_mem[idx_f];

  // Fetch lookup reads the array directly, so a same-cycle write is not seen.
  assign HitF        = valid_q[idx_f] && (tag_mem[idx_f] == tag_f);
  assign PredTakenF  = HitF && pred_taken;
  assign PCNextPredF = PredTakenF ? target_f : pc_plus4(PCF);

  assign pred_f.taken  = PredTakenF;
  assign pred_f.target = target_f;

  btb_pred_pipe u_pred_pipe (
    .clk     (clk),
    .reset   (reset),
    .stall_d (StallD),
    .flush_d (FlushD),
    .flush_e (FlushE),
    .pred_f  (pred_f),
    .pred_e  (pred_e)
  );

  always_comb begin
    MispredictE = 1'b0;
    RedirectPCE = pc_plus4(PCE);
    case (PCsrcE)
      PCSRC_BRANCH: begin
        MispredictE = (pred_e.taken != BranchCondE) ||
                      (pred_e.taken && BranchCondE && (pred_e.target != PCTargetE));
        RedirectPCE = BranchCondE ? PCTargetE : pc_plus4(PCE);
      end
      PCSRC_SEQ: begin
        // A taken prediction on a non-branch means the entry is stale.
        MispredictE = pred_e.taken;
      end
      default: begin
        MispredictE = 1'b0;
      end
    endcase
  end

  assign install_e    = (PCsrcE == PCSRC_BRANCH) && BranchCondE;
  assign invalidate_e = (PCsrcE == PCSRC_SEQ) && pred_e.taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (install_e) begin
      valid_q[idx_e] <= 1'b1;
    end else if (invalidate_e) begin
      valid_q[idx_e] <= 1'b0;
    end
  end

  // Tag and target storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (install_e) begin
      tag_mem[idx_e]    <= tag_e;
      target_mem[idx_e] <= PCTargetE;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;
  import branch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        pred_taken;
  logic        HitF;
  logic        PredTakenF;
  logic [31:0] PCNextPredF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] PCE;
  logic [1:0]  PCsrcE;
  logic        BranchCondE;
  logic [31:0] PCTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .pred_taken  (pred_taken),
    .HitF        (HitF),
    .PredTakenF  (PredTakenF),
    .PCNextPredF (PCNextPredF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .PCE         (PCE),
    .PCsrcE      (PCsrcE),
    .BranchCondE (BranchCondE),
    .PCTargetE   (PCTargetE),
    .MispredictE (MispredictE),
    .RedirectPCE (RedirectPCE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    pred_taken  = 1'b0;
    PCsrcE      = PCSRC_SEQ;
    BranchCondE = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic install(input logic [31:0] pc, input logic [31:0] tgt);
    PCE = pc; PCsrcE = PCSRC_BRANCH; BranchCondE = 1'b1; PCTargetE = tgt;
    step();
    idle_inputs();
  endtask

  // Two clean edges: the lookup at pc ends up in the E register.
  task automatic push_pred(input logic [31:0] pc);
    PCF = pc; pred_taken = 1'b1;
    step();
    PCF = 32'h0; pred_taken = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; PCF = 32'h100; PCE = 32'h200; PCTargetE = 32'h0;
    idle_inputs(); pred_taken = 1'b1;
    #2;
    checks++; if (HitF !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", HitF); end
    checks++; if (PCNextPredF !== 32'h104) begin errors++; $display("FAIL reset_next: got %h want 00000104", PCNextPredF); end
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", MispredictE); end
    checks++; if (RedirectPCE !== 32'h204) begin errors++; $display("FAIL reset_redirect: got %h want 00000204", RedirectPCE); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_install();
    PCF = 32'h100; pred_taken = 1'b1;
    PCE = 32'h100; PCsrcE = PCSRC_BRANCH; BranchCondE = 1'b1; PCTargetE = 32'h80;
    #1;
    checks++; if (HitF !== 1'b0) begin errors++; $display("FAIL cold_hit: got %0b want 0", HitF); end
    checks++; if (PCNextPredF !== 32'h104) begin errors++; $display("FAIL cold_next: got %h want 00000104", PCNextPredF); end
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL cold_mispredict: got %0b want 1", MispredictE); end
    checks++; if (RedirectPCE !== 32'h80) begin errors++; $display("FAIL cold_redirect: got %h want 00000080", RedirectPCE); end
    step();
    idle_inputs(); pred_taken = 1'b1;
    #1;
    checks++; if (HitF !== 1'b1) begin errors++; $display("FAIL warm_hit: got %0b want 1", HitF); end
    checks++; if (PCNextPredF !== 32'h80) begin errors++; $display("FAIL warm_next: got %h want 00000080", PCNextPredF); end
    pred_taken = 1'b0;
    #1;
    checks++; if (HitF !== 1'b1 || PredTakenF !== 1'b0) begin errors++; $display("FAIL warm_nt_flags: got hit=%0b pt=%0b want hit=1 pt=0", HitF, PredTakenF); end
    checks++; if (PCNextPredF !== 32'h104) begin errors++; $display("FAIL warm_nt_next: got %h want 00000104", PCNextPredF); end
  endtask

  task automatic test_resolve();
    push_pred(32'h100);
    PCE = 32'h100; PCsrcE = PCSRC_BRANCH; BranchCondE = 1'b0; PCTargetE = 32'h80;
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL wrong_dir_mispredict: got %0b want 1", MispredictE); end
    checks++; if (RedirectPCE !== 32'h104) begin errors++; $display("FAIL wrong_dir_redirect: got %h want 00000104", RedirectPCE); end
    step();
    idle_inputs(); PCF = 32'h100;
    #1;
    checks++; if (HitF !== 1'b1) begin errors++; $display("FAIL not_taken_keeps_entry: got %0b want 1", HitF); end
    push_pred(32'h100);
    PCE = 32'h100; PCsrcE = PCSRC_BRANCH; BranchCondE = 1'b1; PCTargetE = 32'h90;
    #1;
    checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h90) begin errors++; $display("FAIL target_mismatch: got mp=%0b pc=%h want mp=1 pc=00000090", MispredictE, RedirectPCE); end
    PCTargetE = 32'h80;
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL correct_taken: got %0b want 0", MispredictE); end
    PCsrcE = PCSRC_JALR;
    #1;
    checks++; if (MispredictE !== 1'b0 || RedirectPCE !== 32'h104) begin errors++; $display("FAIL jalr_no_mispredict: got mp=%0b pc=%h want mp=0 pc=00000104", MispredictE, RedirectPCE); end
    PCsrcE = PCSRC_BRANCH;
    step();
    idle_inputs();
  endtask

  task automatic test_alias();
    PCE = 32'h140; PCsrcE = PCSRC_BRANCH; BranchCondE = 1'b1; PCTargetE = 32'h200;
    PCF = 32'h140; pred_taken = 1'b1;
    #1;
    checks++; if (HitF !== 1'b0) begin errors++; $display("FAIL collision_hit: got %0b want 0", HitF); end
    step();
    idle_inputs(); PCF = 32'h100;
    #1;
    checks++; if (HitF !== 1'b0) begin errors++; $display("FAIL alias_old_hit: got %0b want 0", HitF); end
    PCF = 32'h140; pred_taken = 1'b1;
    #1;
    checks++; if (HitF !== 1'b1 || PCNextPredF !== 32'h200) begin errors++; $display("FAIL alias_new: got hit=%0b next=%h want hit=1 next=00000200", HitF, PCNextPredF); end
    pred_taken = 1'b0;
  endtask

  task automatic test_stale();
    install(32'h100, 32'h80);
    push_pred(32'h100);
    PCE = 32'h100; PCsrcE = PCSRC_SEQ;
    #1;
    checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin errors++; $display("FAIL stale: got mp=%0b pc=%h want mp=1 pc=00000104", MispredictE, RedirectPCE); end
    step();
    PCF = 32'h100;
    #1;
    checks++; if (HitF !== 1'b0) begin errors++; $display("FAIL stale_invalidated: got %0b want 0", HitF); end
    install(32'h100, 32'h80);
    PCF = 32'h100; pred_taken = 1'b1;
    step();
    PCF = 32'h0; pred_taken = 1'b0; FlushE = 1'b1;
    step();
    FlushE = 1'b0; PCE = 32'h100; PCsrcE = PCSRC_SEQ; PCF = 32'h100;
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL flush_e: got %0b want 0", MispredictE); end
    checks++; if (HitF !== 1'b1) begin errors++; $display("FAIL flush_e_entry_kept: got %0b want 1", HitF); end
  endtask

  task automatic test_stall_flush_and_async_reset();
    PCF = 32'h100; pred_taken = 1'b1;
    step();
    pred_taken = 1'b0; StallD = 1'b1; FlushD = 1'b1;
    step();
    StallD = 1'b0; FlushD = 1'b0;
    step();
    PCE = 32'h100; PCsrcE = PCSRC_SEQ;
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL flush_beats_stall: got %0b want 0", MispredictE); end
    PCF = 32'h100; pred_taken = 1'b1;
    step();
    pred_taken = 1'b0; StallD = 1'b1;
    step();
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL stall_holds_e: got %0b want 0", MispredictE); end
    StallD = 1'b0;
    step();
    #1;
    checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin errors++; $display("FAIL stall_release: got mp=%0b pc=%h want mp=1 pc=00000104", MispredictE, RedirectPCE); end
    checks++; if (HitF !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %0b want 1", HitF); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (HitF !== 1'b0 || MispredictE !== 1'b0) begin errors++; $display("FAIL async_reset: got hit=%0b mp=%0b want 0 0", HitF, MispredictE); end
    checks++; if (PCNextPredF !== 32'h104 || RedirectPCE !== 32'h104) begin errors++; $display("FAIL async_reset_pcs: got next=%h redir=%h want 00000104 00000104", PCNextPredF, RedirectPCE); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (HitF !== 1'b0) begin errors++; $display("FAIL post_reset_hit: got %0b want 0", HitF); end
  endtask

  initial begin
    test_reset();
    test_install();
    test_resolve();
    test_alias();
    test_stale();
    test_stall_flush_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
